// File: rtl/ad1_serial_reader.sv
// Pmod AD1 receive controller: frames nCS/SCLK and shifts two converter
// channels in parallel, returning both 12-bit samples with a DONE strobe.

module ad1_lane #(
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  sdata,
  output logic [FRAME_BITS-1:0] shreg
);
  always_ff @(posedge clk_in) begin
    if (rst || clr)    shreg <= '0;
    else if (shift_en) shreg <= {shreg[FRAME_BITS-2:0], sdata};
  end
endmodule

module ad1_serial_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int QUIET_CYC  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              START,
  input  logic              SDATA1,
  input  logic              SDATA2,
  output logic              nCS,
  output logic              SCLK,
  output logic [DATA_W-1:0] DATA1,
  output logic [DATA_W-1:0] DATA2,
  output logic              DONE,
  output logic              BUSY,
  output logic              FMT_ERR
);
  localparam int NUM_LANES = 2;
  localparam int CNT_MAX   = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int BIT_W     = $clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  // Bits above the sample field must read back as zero from a healthy converter
  localparam logic [FRAME_BITS-1:0] LEAD_MASK = {FRAME_BITS{1'b1}} << DATA_W;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t                                 state_q, state_d;
  logic [CNT_W-1:0]                       div_q, div_d;
  logic [BIT_W-1:0]                       bit_q, bit_d;
  logic                                   sclk_q, sclk_d;
  logic                                   ncs_q, ncs_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   fmt_q, fmt_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]       data_q, data_d;
  logic [NUM_LANES-1:0][FRAME_BITS-1:0]   shreg;
  logic [NUM_LANES-1:0]                   sdata;
  logic [FRAME_BITS-1:0]                  lead;
  logic                                   clr, shift_en;

  assign sdata = {SDATA2, SDATA1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ad1_lane #(.FRAME_BITS(FRAME_BITS)) u_lane (
      .clk_in  (clk_in),
      .rst     (rst),
      .clr     (clr),
      .shift_en(shift_en),
      .sdata   (sdata[l]),
      .shreg   (shreg[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    ncs_d    = ncs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fmt_d    = fmt_q;
    data_d   = data_q;
    lead     = '0;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        state_d = SETUP;
        ncs_d   = 1'b0;
        busy_d  = 1'b1;
        div_d   = '0;
        clr     = 1'b1;
      end
      SETUP: if (div_q == DIV_LAST) begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
      SHIFT: if (div_q != DIV_LAST) begin
        div_d = div_q + CNT_W'(1);
      end else begin
        div_d = '0;
        // Sample on the edge that raises SCLK: data has settled a full low phase
        if (!sclk_q) begin
          sclk_d   = 1'b1;
          shift_en = 1'b1;
        end else if (bit_q == BIT_LAST) begin
          state_d = QUIET;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          for (int l = 0; l < NUM_LANES; l++) begin
            data_d[l] = shreg[l][DATA_W-1:0];
            lead      = lead | (shreg[l] & LEAD_MASK);
          end
          fmt_d = |lead;
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q + BIT_W'(1);
        end
      end
      QUIET: if (div_q == QUIET_LAST) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fmt_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fmt_q   <= fmt_d;
      data_q  <= data_d;
    end
  end

  assign nCS     = ncs_q;
  assign SCLK    = sclk_q;
  assign DATA1   = data_q[0];
  assign DATA2   = data_q[1];
  assign DONE    = done_q;
  assign BUSY    = busy_q;
  assign FMT_ERR = fmt_q;
endmodule

// File: tb/tb_ad1_serial_reader.sv
// Bench for ad1_serial_reader: CLK_DIV=4 and CLK_DIV=2 instances fed by a
// behavioural AD1 converter model that shifts frames out MSB first on SCLK fall.

module tb_ad1_serial_reader;
  localparam int FB = 16;
  localparam int QC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [1:0]       start_v = '0;
  logic [1:0]       sd1_v = '0, sd2_v = '0;
  logic [1:0]       ncs_v, sclk_v, done_v, busy_v, fmt_v;
  logic [1:0][11:0] d1_v, d2_v;

  logic [15:0] fr1[2], fr2[2];
  int          idx[2], falls[2], bad[2];
  logic [1:0]  ncs_p = 2'b11, sclk_p = 2'b11;

  int ncmp = 0, nerr = 0;
  int last_dc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad1_serial_reader #(.CLK_DIV(4), .FRAME_BITS(FB), .DATA_W(12), .QUIET_CYC(QC)) dut_a (
    .clk_in(clk), .rst(rst), .START(start_v[0]), .SDATA1(sd1_v[0]), .SDATA2(sd2_v[0]),
    .nCS(ncs_v[0]), .SCLK(sclk_v[0]), .DATA1(d1_v[0]), .DATA2(d2_v[0]),
    .DONE(done_v[0]), .BUSY(busy_v[0]), .FMT_ERR(fmt_v[0]));

  ad1_serial_reader #(.CLK_DIV(2), .FRAME_BITS(FB), .DATA_W(12), .QUIET_CYC(QC)) dut_b (
    .clk_in(clk), .rst(rst), .START(start_v[1]), .SDATA1(sd1_v[1]), .SDATA2(sd2_v[1]),
    .nCS(ncs_v[1]), .SCLK(sclk_v[1]), .DATA1(d1_v[1]), .DATA2(d2_v[1]),
    .DONE(done_v[1]), .BUSY(busy_v[1]), .FMT_ERR(fmt_v[1]));

  // Converter model: a new frame begins at nCS fall; each SCLK fall presents the next bit
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ncs_p[k] && !ncs_v[k]) begin
        idx[k]   = 0;
        falls[k] = 0;
      end
      if (sclk_p[k] && !sclk_v[k]) begin
        if (ncs_v[k]) bad[k]++;
        else begin
          falls[k]++;
          if (idx[k] < FB) begin
            sd1_v[k] = fr1[k][15-idx[k]];
            sd2_v[k] = fr2[k][15-idx[k]];
            idx[k]++;
          end
        end
      end
      ncs_p[k]  = ncs_v[k];
      sclk_p[k] = sclk_v[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rnd_frame();
    logic [15:0] f;
    f = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 1) == 1) f = f & 16'h0FFF;
    return f;
  endfunction

  // Called at a negedge; returns at the negedge where BUSY is first seen low
  task automatic run(input int k, input logic [15:0] x1, input logic [15:0] x2,
                     input int ign1, input int ign2);
    int c, lat, idle, nd, fd, bad0;
    logic [11:0] o1, o2;
    logic of, ocs;
    c = (k == 0) ? 4 : 2;
    fr1[k] = x1; fr2[k] = x2;
    bad0 = bad[k];
    lat = -1; idle = -1; nd = 0; fd = -1;
    o1 = 'x; o2 = 'x; of = 1'bx; ocs = 1'bx;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (done_v[k]) begin
        nd++;
        if (lat < 0) begin
          lat = n; last_dc = cyc;
          o1 = d1_v[k]; o2 = d2_v[k]; of = fmt_v[k]; ocs = ncs_v[k]; fd = falls[k];
        end
      end
      if (!busy_v[k]) begin
        idle = n;
        break;
      end
      start_v[k] = (n == ign1 || n == ign2);
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    check($sformatf("latency%0d", k), lat, c * (1 + 2 * FB) + 1);
    check($sformatf("busy_low%0d", k), idle, c * (1 + 2 * FB) + 1 + QC);
    check($sformatf("done_count%0d", k), nd, 1);
    check($sformatf("data1_%0d", k), o1, x1 % 4096);
    check($sformatf("data2_%0d", k), o2, x2 % 4096);
    check($sformatf("fmt_err%0d", k), of, ((x1 | x2) >= 16'h1000));
    check($sformatf("ncs_at_done%0d", k), ocs, 1);
    check($sformatf("sclk_falls%0d", k), fd, FB);
    check($sformatf("sclk_edge_cs_high%0d", k), bad[k] - bad0, 0);
    check($sformatf("data1_hold%0d", k), d1_v[k], x1 % 4096);
  endtask

  initial begin
    int dc1, n;
    logic [15:0] a, b;
    fr1[0] = '0; fr2[0] = '0; fr1[1] = '0; fr2[1] = '0;
    idx[0] = 0; idx[1] = 0; falls[0] = 0; falls[1] = 0; bad[0] = 0; bad[1] = 0;
    last_dc = 0;
    repeat (5) @(negedge clk);
    check("rst_ncs", ncs_v[0], 1);
    check("rst_sclk", sclk_v[0], 1);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_data", {d1_v[0], d2_v[0], fmt_v[0]}, 0);
    check("rst_b", {ncs_v[1], sclk_v[1], busy_v[1]}, 3'b110);
    rst = 1'b0;
    while (cyc < 19) @(negedge clk);

    run(0, 16'h0ABC, 16'h0123, -1, -1);
    run(0, 16'h0FFF, 16'h0FFF, -1, -1);
    run(0, 16'h8001, 16'h0000, -1, -1);
    run(0, rnd_frame(), rnd_frame(), 10, 100);
    dc1 = last_dc;
    run(0, rnd_frame(), rnd_frame(), -1, -1);
    check("back_to_back", last_dc - dc1, 4 * (1 + 2 * FB) + 1 + QC);
    repeat (3) run(0, rnd_frame(), rnd_frame(), -1, -1);
    run(0, 16'h0F5A, 16'h0C3D, -1, -1);

    // Abort mid-frame, with a START coinciding with reset
    fr1[0] = 16'h0777; fr2[0] = 16'h0888;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (falls[0] < 8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit8", falls[0] >= 8, 1);
    rst = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("abort_ncs", ncs_v[0], 1);
    check("abort_sclk", sclk_v[0], 1);
    check("abort_busy", busy_v[0], 0);
    check("abort_data", {d1_v[0], d2_v[0]}, 0);
    check("abort_done", done_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_v[0]) n++;
      @(negedge clk);
    end
    check("abort_no_done", n, 0);
    check("abort_stay_idle", busy_v[0], 0);
    a = rnd_frame(); b = rnd_frame();
    run(0, a, b, -1, -1);

    run(1, 16'h0555, 16'h0AAA, -1, -1);
    run(1, rnd_frame(), rnd_frame(), 5, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
